// File: rtl/clkdiv_gated_ctrl_if.sv
// clkdiv_gated_ctrl_if: control and clock-output bundle for the gated clock divider
//   EN     enable request (master -> divider)
//   DIV    half-period minus one (master -> divider)
//   Z      divided clock (divider -> master)
//   ACTIVE divider running or draining (divider -> master)
interface clkdiv_gated_ctrl_if #(
    parameter int W = 4
);
    logic         EN;
    logic [W-1:0] DIV;
    logic         Z;
    logic         ACTIVE;
    modport master (output EN, DIV, input Z, ACTIVE);
    modport slave (input EN, DIV, output Z, ACTIVE);
endinterface

// File: rtl/clkdiv_gated_ctrl.sv
// clkdiv_gated_ctrl: glitch-free 50% duty programmable clock divider, ratio 2*(DIV+1)
//   CLK  source clock, rising edge
//   RN   asynchronous active-low reset
//   bus  slave side: EN, DIV in; Z (flop-driven divided clock), ACTIVE out
module clkdiv_gated_ctrl #(
    parameter int W = 4
) (
    input logic                CLK,
    input logic                RN,
    clkdiv_gated_ctrl_if.slave bus
);
    typedef enum logic [1:0] {OFF, RUN, DRAIN} state_t;
    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n, div_q, div_n;
    logic         z, z_n, active;
    logic         hit;
    assign hit = cnt == div_q;
    always_comb begin
        state_n = state;
        cnt_n   = hit ? '0 : cnt + 1'b1;
        z_n     = hit ? ~z : z;
        div_n   = div_q;
        case (state)
            OFF: begin
                cnt_n = '0;
                z_n   = 1'b0;
                if (bus.EN) begin
                    state_n = RUN;
                    div_n   = bus.DIV;
                end
            end
            RUN: begin
                // the falling edge of Z is the only point a new ratio is taken
                if (hit && z) div_n = bus.DIV;
                if (!bus.EN) begin
                    if (!z) begin
                        // stop during low: hold low, never shorten it
                        state_n = OFF;
                        cnt_n   = '0;
                        z_n     = 1'b0;
                    end else begin
                        state_n = hit ? OFF : DRAIN;
                    end
                end
            end
            DRAIN: state_n = hit ? OFF : DRAIN;
            default: state_n = OFF;
        endcase
    end
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= OFF;
            cnt    <= '0;
            div_q  <= '0;
            z      <= 1'b0;
            active <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            div_q  <= div_n;
            z      <= z_n;
            active <= state_n != OFF;
        end
    end
    assign bus.Z      = z;
    assign bus.ACTIVE = active;
endmodule

// File: tb/tb_clkdiv_gated_ctrl.sv
// tb_clkdiv_gated_ctrl: scoreboard bench; expected Z/ACTIVE transitions are queued by stimulus and matched by a monitor
module tb_clkdiv_gated_ctrl;
    typedef struct {
        int   c;
        logic z;
        logic a;
    } ev_t;
    logic  CLK;
    logic  RN;
    logic  fin;
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    k;
    logic [1:0] prev = 2'b00;
    ev_t   q[$];
    clkdiv_gated_ctrl_if #(.W(4)) bus ();
    clkdiv_gated_ctrl #(.W(4)) dut (.CLK(CLK), .RN(RN), .bus(bus));
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end
    always @(posedge CLK) cyc <= cyc + 1;
    task automatic push(input int c, input logic z, input logic a);
        q.push_back('{c: c, z: z, a: a});
    endtask
    task automatic wait_to(input int e);
        do @(negedge CLK); while (cyc < e);
    endtask
    always @(negedge CLK or negedge RN) begin
        if (!RN) begin
            #1;
            n_chk++;
            if (bus.Z !== 1'b0 || bus.ACTIVE !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: Z=%b ACTIVE=%b required Z=0 ACTIVE=0 at t=%0t", bus.Z, bus.ACTIVE, $time);
            end
            prev = {bus.Z, bus.ACTIVE};
        end else if (fin) begin
            n_chk++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL missing_events: %0d pending, next expected at edge %0d Z=%b ACTIVE=%b", q.size(), q[0].c, q[0].z, q[0].a);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end else if ({bus.Z, bus.ACTIVE} !== prev) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: edge %0d Z=%b ACTIVE=%b, required no change", cyc, bus.Z, bus.ACTIVE);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.c != cyc || e.z !== bus.Z || e.a !== bus.ACTIVE) begin
                    n_fail++;
                    $display("FAIL transition: edge %0d Z=%b ACTIVE=%b, required edge %0d Z=%b ACTIVE=%b", cyc, bus.Z, bus.ACTIVE, e.c, e.z, e.a);
                end
            end
            prev = {bus.Z, bus.ACTIVE};
        end
    end
    initial begin
        RN = 1'b1;
        fin = 1'b0;
        bus.EN = 1'b0;
        bus.DIV = 4'd3;
        #2 RN = 1'b0;
        wait_to(2);
        k = cyc + 1;
        RN = 1'b1;
        bus.EN = 1'b1;
        push(k, 0, 1);
        push(k + 4, 1, 1);
        push(k + 8, 0, 1);
        push(k + 12, 1, 1);
        push(k + 16, 0, 1);
        wait_to(k + 17);
        bus.EN = 1'b0;
        push(k + 18, 0, 0);
        wait_to(k + 18);
        bus.EN = 1'b1;
        push(k + 19, 0, 1);
        push(k + 23, 1, 1);
        wait_to(k + 23);
        bus.EN = 1'b0;
        wait_to(k + 24);
        bus.EN = 1'b1;
        wait_to(k + 25);
        bus.EN = 1'b0;
        push(k + 27, 0, 0);
        wait_to(k + 29);
        k = cyc + 1;
        bus.DIV = 4'd0;
        bus.EN = 1'b1;
        for (int i = 0; i < 6; i++) push(k + i, i[0], 1);
        wait_to(k + 5);
        bus.EN = 1'b0;
        push(k + 6, 0, 0);
        wait_to(k + 8);
        k = cyc + 1;
        bus.DIV = 4'd2;
        bus.EN = 1'b1;
        push(k, 0, 1);
        push(k + 3, 1, 1);
        push(k + 6, 0, 1);
        push(k + 12, 1, 1);
        push(k + 18, 0, 1);
        wait_to(k + 4);
        bus.DIV = 4'd5;
        wait_to(k + 18);
        bus.EN = 1'b0;
        push(k + 19, 0, 0);
        wait_to(k + 21);
        k = cyc + 1;
        bus.DIV = 4'd7;
        bus.EN = 1'b1;
        push(k, 0, 1);
        push(k + 8, 1, 1);
        wait_to(k + 9);
        @(posedge CLK);
        #2 RN = 1'b0;
        repeat (3) @(negedge CLK);
        k = cyc + 1;
        RN = 1'b1;
        push(k, 0, 1);
        push(k + 8, 1, 1);
        push(k + 16, 0, 1);
        wait_to(k + 16);
        bus.EN = 1'b0;
        push(k + 17, 0, 0);
        wait_to(k + 20);
        fin = 1'b1;
    end
endmodule
